// File: rtl/imem_loader.sv
// imem_loader: instruction memory with a one-cycle synchronous read port for
// the fetch stage, plus a big-endian byte-stream program loader
// (valid/ready). The core is held in reset for the whole load and released
// after a one-cycle flush, so it boots from the freshly written word 0.
// Optional: define IMEM_LOADER_CHECKSUM_EN to add the load_csum output
// (8-bit running sum of the bytes of the most recent load).
module imem_loader #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [7:0]            load_byte,
  input  logic                  load_last,
  output logic                  cpu_reset,
  output logic [ADDR_WIDTH:0]   load_count,
  output logic                  overflow
`ifdef IMEM_LOADER_CHECKSUM_EN
  ,
  output logic [7:0]            load_csum
`endif
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {RUN, LOAD, FLUSH} state_t;

  state_t                state;
  logic [BW-1:0]         bcnt;
  logic [DATA_WIDTH-1:0] acc;
  logic [ADDR_WIDTH-1:0] wptr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  xfer;
  logic                  first;
  logic                  word_done;
  logic                  wr_en;
  logic [BW-1:0]         bcnt_eff;
  logic [DATA_WIDTH-1:0] acc_eff;
  logic [DATA_WIDTH-1:0] acc_next;
  logic [DATA_WIDTH-1:0] word;
  logic [ADDR_WIDTH-1:0] wptr_eff;
  logic [ADDR_WIDTH:0]   count_eff;
  logic                  ovf_eff;

  // Transfer decode. A transfer seen in RUN starts a new load on that same
  // edge, so the per-load state is substituted with its restart values
  // ("_eff") instead of spending a cycle clearing it.
  always_comb begin
    xfer      = load_valid && load_ready;
    first     = (state == RUN);
    bcnt_eff  = first ? '0 : bcnt;
    acc_eff   = first ? '0 : acc;
    wptr_eff  = first ? '0 : wptr;
    count_eff = first ? '0 : load_count;
    ovf_eff   = first ? 1'b0 : overflow;
    acc_next  = (acc_eff << 8) | DATA_WIDTH'(load_byte);
    word_done = (bcnt_eff == BW'(BYTES - 1));
    // Left-align a short final word; a full word shifts by zero.
    word      = acc_next << (8 * (BYTES - 1 - int'(bcnt_eff)));
    wr_en     = xfer && !reset && (word_done || load_last);
  end

  // Memory write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wptr_eff] <= word;
    end
  end

  // Control FSM, read port and load bookkeeping, all registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RUN;
      ram_data   <= '0;
      cpu_reset  <= 1'b0;
      load_ready <= 1'b1;
      load_count <= '0;
      overflow   <= 1'b0;
      bcnt       <= '0;
      acc        <= '0;
      wptr       <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      load_csum  <= '0;
`endif
    end else begin
      if (state == RUN) begin
        ram_data <= mem[ram_addr];
      end else begin
        ram_data <= '0;
      end

      if (xfer) begin
        acc       <= acc_next;
        cpu_reset <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        load_csum <= (first ? 8'h00 : load_csum) + load_byte;
`endif
        if (word_done || load_last) begin
          bcnt       <= '0;
          wptr       <= wptr_eff + 1'b1;
          load_count <= (count_eff == FULL_COUNT) ? count_eff : count_eff + 1'b1;
          overflow   <= ovf_eff || (count_eff == FULL_COUNT);
        end else begin
          bcnt       <= bcnt_eff + 1'b1;
          wptr       <= wptr_eff;
          load_count <= count_eff;
          overflow   <= ovf_eff;
        end
        if (load_last) begin
          state      <= FLUSH;
          load_ready <= 1'b0;
        end else begin
          state      <= LOAD;
          load_ready <= 1'b1;
        end
      end else begin
        case (state)
          RUN: begin
            cpu_reset  <= 1'b0;
            load_ready <= 1'b1;
          end
          LOAD: begin
            cpu_reset  <= 1'b1;
            load_ready <= 1'b1;
          end
          FLUSH: begin
            state      <= RUN;
            cpu_reset  <= 1'b0;
            load_ready <= 1'b1;
            bcnt       <= '0;
          end
          default: begin
            state      <= RUN;
            cpu_reset  <= 1'b0;
            load_ready <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
